// File: rtl/citron_timer.sv
// Citron bus 64-bit timer: prescaler, 64-bit compare, sticky MATCHED flag and level IRQ.
// Optional macro CITRON_TIMER_AUTORELOAD_EN enables CTRL[2] AUTORELOAD (count clears on match).
module citron_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  citron_addr,
    input  logic        citron_rdy,
    input  logic        citron_wr,
    input  logic [31:0] citron_writedata,
    output logic [31:0] citron_readdata,
    output logic        citron_stall,
    output logic        citron_match,
    output logic        irq_o
);
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_PRESCALE = 3'd2;
    localparam logic [2:0] OFF_CNT_LO   = 3'd3;
    localparam logic [2:0] OFF_CNT_HI   = 3'd4;
    localparam logic [2:0] OFF_CMP_LO   = 3'd5;
    localparam logic [2:0] OFF_CMP_HI   = 3'd6;

    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        ar_q;
    logic        matched_q, matched_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] psc_q, psc_d;
    logic [63:0] count_q, count_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        irq_q, irq_d;

    logic        wr_en, rd_en, tick, hit_cmp;
    logic [2:0]  off;
    logic [31:0] reg_val;

`ifdef CITRON_TIMER_AUTORELOAD_EN
    logic ar_d;
`else
    assign ar_q = 1'b0;
`endif

    assign citron_match    = (citron_addr[7:3] == BASE_ADDR[7:3]);
    assign citron_stall    = 1'b0;
    assign citron_readdata = rd_data_q;
    assign irq_o           = irq_q;

    assign off     = citron_addr[2:0];
    assign wr_en   = citron_rdy & citron_wr & citron_match;
    assign rd_en   = citron_rdy & ~citron_wr & citron_match;
    assign tick    = en_q && (psc_q == prescale_q);
    assign hit_cmp = (count_q == cmp_q);

    // COUNT_HI reads the snapshot taken by the last COUNT_LO read, so 64-bit reads never tear.
    always_comb begin
        reg_val = 32'h0;
        case (off)
            OFF_CTRL:     reg_val = {29'h0, ar_q, irq_en_q, en_q};
            OFF_STATUS:   reg_val = {31'h0, matched_q};
            OFF_PRESCALE: reg_val = {16'h0, prescale_q};
            OFF_CNT_LO:   reg_val = count_q[31:0];
            OFF_CNT_HI:   reg_val = hi_snap_q;
            OFF_CMP_LO:   reg_val = cmp_q[31:0];
            OFF_CMP_HI:   reg_val = cmp_q[63:32];
            default:      reg_val = 32'h0;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
`ifdef CITRON_TIMER_AUTORELOAD_EN
        ar_d       = ar_q;
`endif
        matched_d  = matched_q;
        prescale_d = prescale_q;
        cmp_d      = cmp_q;
        hi_snap_d  = hi_snap_q;
        rd_data_d  = rd_data_q;
        psc_d      = (!en_q || tick) ? 16'h0 : psc_q + 16'd1;
        count_d    = count_q;

        if (tick)
            count_d = (ar_q && hit_cmp) ? 64'h0 : count_q + 64'd1;

        // CPU writes override the tick update; a count write rebuilds from the pre-tick value.
        if (wr_en) begin
            case (off)
                OFF_CTRL: begin
                    en_d     = citron_writedata[0];
                    irq_en_d = citron_writedata[1];
`ifdef CITRON_TIMER_AUTORELOAD_EN
                    ar_d     = citron_writedata[2];
`endif
                end
                OFF_STATUS:   if (citron_writedata[0]) matched_d = 1'b0;
                OFF_PRESCALE: begin
                    prescale_d = citron_writedata[15:0];
                    psc_d      = 16'h0;
                end
                OFF_CNT_LO: begin
                    count_d = {count_q[63:32], citron_writedata};
                    psc_d   = 16'h0;
                end
                OFF_CNT_HI: begin
                    count_d = {citron_writedata, count_q[31:0]};
                    psc_d   = 16'h0;
                end
                OFF_CMP_LO:   cmp_d[31:0]  = citron_writedata;
                OFF_CMP_HI:   cmp_d[63:32] = citron_writedata;
                default:      ;
            endcase
        end

        if (tick && hit_cmp)
            matched_d = 1'b1;

        if (citron_rdy) begin
            rd_data_d = rd_en ? reg_val : 32'h0;
            if (rd_en && off == OFF_CNT_LO)
                hi_snap_d = count_q[63:32];
        end

        irq_d = matched_d & irq_en_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
`ifdef CITRON_TIMER_AUTORELOAD_EN
            ar_q       <= 1'b0;
`endif
            matched_q  <= 1'b0;
            prescale_q <= 16'h0;
            psc_q      <= 16'h0;
            count_q    <= 64'h0;
            cmp_q      <= 64'h0;
            hi_snap_q  <= 32'h0;
            rd_data_q  <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
`ifdef CITRON_TIMER_AUTORELOAD_EN
            ar_q       <= ar_d;
`endif
            matched_q  <= matched_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            hi_snap_q  <= hi_snap_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_citron_timer.sv
// Directed self-checking bench for citron_timer; each bus access consumes exactly one clock edge.
module tb_citron_timer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  citron_addr = 8'h0;
    logic        citron_rdy = 1'b0;
    logic        citron_wr = 1'b0;
    logic [31:0] citron_writedata = 32'h0;
    logic [31:0] citron_readdata;
    logic        citron_stall;
    logic        citron_match;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] A_CTRL = 8'h10, A_STAT = 8'h11, A_PSC = 8'h12, A_CLO = 8'h13,
                           A_CHI = 8'h14, A_MLO = 8'h15, A_MHI = 8'h16, A_RSV = 8'h17;

    citron_timer #(.BASE_ADDR(8'h10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .citron_addr(citron_addr), .citron_rdy(citron_rdy),
        .citron_wr(citron_wr), .citron_writedata(citron_writedata),
        .citron_readdata(citron_readdata), .citron_stall(citron_stall),
        .citron_match(citron_match), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        citron_addr = a; citron_writedata = d; citron_wr = 1'b1; citron_rdy = 1'b1;
        @(posedge clk_i);
        #1;
        citron_rdy = 1'b0; citron_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        citron_addr = a; citron_wr = 1'b0; citron_rdy = 1'b1;
        @(posedge clk_i);
        #1;
        citron_rdy = 1'b0;
        d = citron_readdata;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd(8'h10 + 8'(i), d);
            n_cmp++;
            if (d !== 32'h0) begin
                n_bad++; $display("FAIL reset_read off%0d: got %h want 0", i, d);
            end
        end
        n_cmp++;
        if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    endtask

    task automatic test_decode();
        logic [7:0] addrs [4] = '{8'h0F, 8'h10, 8'h17, 8'h18};
        logic       exp   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            citron_addr = addrs[i];
            #1;
            n_cmp++;
            if (citron_match !== exp[i] || citron_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL decode %h: match=%b stall=%b want match=%b stall=0",
                         addrs[i], citron_match, citron_stall, exp[i]);
            end
        end
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'hABCD_1234); rd(A_PSC, d);
        n_cmp++; if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL prescale_rb: got %h want 00001234", d); end
        wr(A_MHI, 32'hDEAD_BEEF); rd(A_MHI, d);
        n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL cmp_hi_rb: got %h want deadbeef", d); end
        wr(A_RSV, 32'hFFFF_FFFF); rd(A_RSV, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reserved_rb: got %h want 0", d); end
        wr(A_CTRL, 32'hFFFF_FFFA); rd(A_CTRL, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL ctrl_rb: got %h want 2", d); end
    endtask

    task automatic test_prescaler_irq();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd3); wr(A_MLO, 32'd5); wr(A_MHI, 32'd0);
        wr(A_CTRL, 32'd3);
        // count reaches 5 after 20 edges, its next tick lands on edge 24
        idle(23);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq_o); end
        idle(1);
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_match: got %b want 1", irq_o); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL status_set: got %h want 1", d); end
        rd(8'h20, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL foreign_read: got %h want 0", d); end
        wr(A_STAT, 32'h1);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", irq_o); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL status_w1c: got %h want 0", d); end
    endtask

    task automatic test_count_rollover();
        logic [31:0] lo, hi;
        do_reset();
        wr(A_CHI, 32'h0); wr(A_CLO, 32'hFFFF_FFFE); wr(A_PSC, 32'h0);
        wr(A_CTRL, 32'h1);
        rd(A_CLO, lo); rd(A_CHI, hi);
        n_cmp++;
        if (lo !== 32'hFFFF_FFFE || hi !== 32'h0) begin
            n_bad++; $display("FAIL snap_pre: got %h_%h want 00000000_fffffffe", hi, lo);
        end
        rd(A_CLO, lo); rd(A_CHI, hi);
        n_cmp++;
        if (lo !== 32'h0 || hi !== 32'h1) begin
            n_bad++; $display("FAIL snap_post: got %h_%h want 00000001_00000000", hi, lo);
        end
    endtask

    task automatic test_ctrl_autoreload();
        logic [31:0] d;
        do_reset();
`ifdef CITRON_TIMER_AUTORELOAD_EN
        wr(A_MLO, 32'd4); wr(A_PSC, 32'd1);
        wr(A_CTRL, 32'd7);
        idle(9);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ar_pre1: got %h want 0", d); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ar_match1: got %h want 1", d); end
        wr(A_STAT, 32'h1);
        idle(7);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ar_pre2: got %h want 0", d); end
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ar_match2: got %h want 1", d); end
        rd(A_CLO, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ar_reload: got %h want 0", d); end
`else
        wr(A_CTRL, 32'd7);
        rd(A_CTRL, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL ctrl_no_ar: got %h want 3", d); end
`endif
    endtask

    task automatic test_write_tick_collision();
        logic [31:0] d;
        do_reset();
        wr(A_CTRL, 32'h1);
        wr(A_CLO, 32'h100);
        rd(A_CLO, d);
        n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL cnt_write_tick: got %h want 00000100", d); end
        rd(A_CHI, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL cnt_write_hi: got %h want 0", d); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        do_reset();
        wr(A_CLO, 32'd10); wr(A_MLO, 32'd12);
        wr(A_CTRL, 32'h1);
        idle(2);
        wr(A_STAT, 32'h1);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL w1c_vs_set: got %h want 1", d); end
        wr(A_STAT, 32'h1);
        rd(A_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL w1c_plain: got %h want 0", d); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got %b want 0", irq_o); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        do_reset();
        wr(A_CLO, 32'h50); wr(A_CTRL, 32'h3);
        idle(2);
        rd(A_CLO, d);
        n_cmp++; if (d !== 32'h52) begin n_bad++; $display("FAIL mid_count: got %h want 00000052", d); end
        citron_addr = A_CLO; citron_wr = 1'b0; citron_rdy = 1'b1; rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        citron_rdy = 1'b0; rst_i = 1'b0;
        n_cmp++;
        if (citron_readdata !== 32'h0 || irq_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_outputs: rdata=%h irq=%b want 0/0", citron_readdata, irq_o);
        end
        idle(3);
        rd(A_CLO, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_count: got %h want 0", d); end
        rd(A_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_regmap();
        test_prescaler_irq();
        test_count_rollover();
        test_ctrl_autoreload();
        test_write_tick_collision();
        test_w1c_collision();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
